// File: rtl/seq_mult64.sv
// seq_mult64 -- iterative shift-and-add multiplier (low 64 bits of a*b).
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    request, sampled only while idle
//   a, b     multiplicand / multiplier, captured on the accepted start edge
//   busy     high while an operation is in flight (RUN or DONE)
//   done     one-cycle pulse when product is final
//   product  low 64 bits of a*b; held until the next accepted start
//
// Also contains adder64, the ripple adder used as the accumulate datapath.

// adder64 -- 64-bit ripple-carry adder. The carry out of bit 63 is not
// produced: the only consumer works mod 2^64 and drops it.
module adder64 (
  input  logic [63:0] x,
  input  logic [63:0] y,
  output logic [63:0] sum
);
  logic [63:0] c;  // c[i] = carry into bit i

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 64; i++) begin : g_bit
    assign sum[i] = x[i] ^ y[i] ^ c[i];
    if (i < 63) begin : g_carry
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end
endmodule

module seq_mult64 #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [63:0] acc, mcand, mplier;
  logic [5:0]  count;
  logic [63:0] sum;

  adder64 u_add (
    .x   (acc),
    .y   (mcand),
    .sum (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Exit at the 64th iteration, or earlier once no multiplier bits remain
  // after this one (mplier[63:1] is what mplier becomes on this edge).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (count == 6'd63 || (EARLY_EXIT && mplier[63:1] == 63'd0))
              state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc    <= '0;
          mcand  <= a;
          mplier <= b;
          count  <= '0;
        end
        RUN: begin
          if (mplier[0]) acc <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign product = acc;
endmodule

// File: tb/tb_seq_mult64.sv
module tb_seq_mult64;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic        busy0, done0, busy1, done1;
  logic [63:0] prod0, prod1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // dut0: always 64 iterations; dut1: early exit
  seq_mult64 #(.EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a), .b(b),
    .busy(busy0), .done(done0), .product(prod0));
  seq_mult64 #(.EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b),
    .busy(busy1), .done(done1), .product(prod1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular product and latency from the multiplier's width.
  function automatic logic [63:0] ref_prod(input logic [63:0] x, input logic [63:0] y);
    return x * y;
  endfunction

  function automatic int ref_lat(input int ee, input logic [63:0] y);
    int w;
    if (ee == 0) return 64;
    w = $clog2({1'b0, y} + 65'd1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic sel_busy(input int ee);
    return ee ? busy1 : busy0;
  endfunction
  function automatic logic sel_done(input int ee);
    return ee ? done1 : done0;
  endfunction
  function automatic logic [63:0] sel_prod(input int ee);
    return ee ? prod1 : prod0;
  endfunction

  // One transaction on the chosen DUT. When poke is set, a second start
  // with different operands is raised mid-flight and must be ignored.
  task automatic op(input int ee, input logic [63:0] av, input logic [63:0] bv,
                    input string tag, input bit poke = 1'b0);
    int n;
    int lat;
    lat = ref_lat(ee, bv);
    @(negedge clk);
    a = av; b = bv;
    if (ee != 0) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);                       // capture edge has passed
    start0 = 1'b0; start1 = 1'b0;
    a = $urandom(); b = {$urandom(), $urandom()};  // operands free to change
    chk({tag, ".busy"}, {63'd0, sel_busy(ee)}, 64'd1);
    n = 0;
    while (n < 70) begin
      if (poke && n == 3) begin
        a = 64'd100; b = 64'd100;
        if (ee != 0) start1 = 1'b1; else start0 = 1'b1;
      end
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      n++;
      if (sel_done(ee)) break;
    end
    chk({tag, ".lat"}, 64'(n), 64'(lat));
    chk({tag, ".prod"}, sel_prod(ee), ref_prod(av, bv));
    @(negedge clk);
    chk({tag, ".idle"}, {62'd0, sel_busy(ee), sel_done(ee)}, 64'd0);
    chk({tag, ".hold"}, sel_prod(ee), ref_prod(av, bv));
  endtask

  initial begin
    logic [63:0] ra, rb;
    int sh;

    #12;
    chk("rst.busy0", {63'd0, busy0}, 64'd0);
    chk("rst.done0", {63'd0, done0}, 64'd0);
    chk("rst.prod0", prod0, 64'd0);
    chk("rst.busy1", {63'd0, busy1}, 64'd0);
    chk("rst.prod1", prod1, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op(0, 64'd3, 64'd5, "basic");
    op(0, '1, '1, "ones0");
    op(1, '1, '1, "ones1");
    op(1, 64'h1234, 64'd0, "b0");
    op(1, 64'd7, 64'd3, "b3");
    op(1, 64'd9, 64'd1, "b1");
    op(1, 64'h8000_0000_0000_0000, 64'd2, "topbit");
    op(0, 64'hFFFF_FFFF_FFFF_FFFA, 64'd7, "neg0");
    op(1, 64'hFFFF_FFFF_FFFF_FFFA, 64'd7, "neg1");
    op(1, 64'd5, 64'h8000_0000_0000_0000, "b63");
    op(0, 64'd2, 64'd9, "restart0", 1'b1);
    op(1, 64'd2, 64'd9, "restart1", 1'b1);

    // start held high: accepted again after one idle cycle
    @(negedge clk);
    a = 64'd7; b = 64'd3; start1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("held.done", {63'd0, done1}, 64'd1);
    chk("held.prod", prod1, 64'd21);
    @(negedge clk);
    chk("held.gap", {63'd0, busy1}, 64'd0);
    @(negedge clk);
    chk("held.reissue", {63'd0, busy1}, 64'd1);
    start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("held.done2", {63'd0, done1}, 64'd1);
    chk("held.prod2", prod1, 64'd21);
    @(negedge clk);

    // reset mid-operation
    a = 64'd5; b = 64'd5; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort.pre", prod0, 64'd25);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.busy", {63'd0, busy0}, 64'd0);
    chk("abort.done", {63'd0, done0}, 64'd0);
    chk("abort.prod", prod0, 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort.nodone", {62'd0, done0, busy0}, 64'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort.stay", {62'd0, done0, busy0}, 64'd0);
    end
    op(0, 64'd4, 64'd4, "post");

    // randomized operands, varied multiplier widths
    for (int i = 0; i < 24; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      sh = $urandom_range(0, 63);
      rb = rb >> sh;
      op(i % 2, ra, rb, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
